// File: rtl/cplx_pkg.sv
// Shared widths and helpers for the complex-arithmetic datapath blocks.
package cplx_pkg;

    localparam int CPLX_N       = 8;
    localparam int CPLX_LEN     = 16;
    localparam int CPLX_ACC_W   = 2 * CPLX_N + $clog2(CPLX_LEN);

    // Clamp a wide signed value into the range of a w-bit two's-complement word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/cplx_sat_add.sv
// One-lane combinational saturating adder: acc + sign-extended addend, clamped to ACC_W.
module cplx_sat_add
    import cplx_pkg::*;
#(
    parameter int IN_W  = 2 * CPLX_N,
    parameter int ACC_W = CPLX_ACC_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  addend,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    logic signed [63:0] wide;
    logic signed [63:0] clamped;

    always_comb begin
        wide    = 64'($signed(acc)) + 64'($signed(addend));
        clamped = sat_signed(wide, ACC_W);
        sum     = clamped[ACC_W-1:0];
        sat     = (clamped != wide);
    end

endmodule

// File: rtl/cplx_frame_accum.sv
// Frame accumulator for complex products: sums LEN samples per lane with saturation
// and presents each frame sum on a one-deep valid/ready register that never stalls upstream.
module cplx_frame_accum
    import cplx_pkg::*;
#(
    parameter int N     = CPLX_N,
    parameter int LEN   = CPLX_LEN,
    parameter int ACC_W = 2 * N + $clog2(LEN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [2*N-1:0]          in_r,
    input  logic [2*N-1:0]          in_i,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_r,
    output logic [ACC_W-1:0]        out_i,
    output logic                    out_sat,
    output logic                    overrun,
    output logic [$clog2(LEN)-1:0]  cnt
);

    localparam int CNT_W = $clog2(LEN);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_i;
    logic [ACC_W-1:0] sum_r;
    logic [ACC_W-1:0] sum_i;
    logic             sat_r;
    logic             sat_i;
    logic             sat_flag;
    logic             accept;
    logic             frame_end;
    logic             frame_sat;

    cplx_sat_add #(.IN_W(2 * N), .ACC_W(ACC_W)) u_add_r (
        .acc    (acc_r),
        .addend (in_r),
        .sum    (sum_r),
        .sat    (sat_r)
    );

    cplx_sat_add #(.IN_W(2 * N), .ACC_W(ACC_W)) u_add_i (
        .acc    (acc_i),
        .addend (in_i),
        .sum    (sum_i),
        .sat    (sat_i)
    );

    // clear takes priority over a sample presented in the same cycle
    assign accept    = in_valid & ~clear;
    assign frame_end = accept && (cnt == CNT_W'(LEN - 1));
    assign frame_sat = sat_flag | sat_r | sat_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r     <= '0;
            acc_i     <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (clear) begin
                acc_r    <= '0;
                acc_i    <= '0;
                cnt      <= '0;
                sat_flag <= 1'b0;
                overrun  <= 1'b0;
            end else if (accept) begin
                if (frame_end) begin
                    acc_r    <= '0;
                    acc_i    <= '0;
                    cnt      <= '0;
                    sat_flag <= 1'b0;
                end else begin
                    acc_r    <= sum_r;
                    acc_i    <= sum_i;
                    cnt      <= cnt + CNT_W'(1);
                    sat_flag <= frame_sat;
                end
            end

            // A frame end always loads; an unaccepted pending result is lost and flagged.
            if (frame_end) begin
                out_r     <= sum_r;
                out_i     <= sum_i;
                out_sat   <= frame_sat;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cplx_frame_accum.md
Name: cplx_frame_accum

Overview:
- Downstream consumer of the pipelined complex multiplier. Accumulates LEN valid complex products (c_r, c_i) per frame into saturating accumulators.
- Presents each frame's sum on a one-deep valid/ready output register.
- Upstream cannot stall, so this block never back-pressures. Overruns are flagged instead.
- Typical use: correlator / dot-product back end.

Parameters:
- N, 8: multiplier operand width. Product input width is 2N.
- LEN, 16: products per frame. Must be >= 2.
- ACC_W, 2N+$clog2(LEN) (=20): accumulator and output width. Must be >= 2N+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  product valid. The multiplier's 4-cycle latency is aligned upstream.
- in_r  in  2N  signed real product
- in_i  in  2N  signed imaginary product
- clear  in  1  synchronous abort of the partial frame; also clears overrun
- out_valid  out  1  frame sum available
- out_ready  in  1  consumer accepts sum
- out_r  out  ACC_W  signed real frame sum
- out_i  out  ACC_W  signed imaginary frame sum
- out_sat  out  1  saturation occurred in either lane during this frame
- overrun  out  1  sticky: a completed frame overwrote an unaccepted result
- cnt  out  $clog2(LEN)  samples accepted in the current frame (debug)

Behaviour:
- Reset (asynchronous): acc_r, acc_i, cnt, out_r, out_i, out_sat, out_valid and overrun all = 0.
- Accept rule: a sample is accepted on every clk edge with in_valid=1 and clear=0. There is no ready toward upstream.
- Sign extension: inputs are sign-extended to ACC_W before addition.
- Saturating add, per lane: sum = acc + ext(in). On positive overflow clamp to 2^(ACC_W-1)-1; on negative overflow clamp to -2^(ACC_W-1). The frame's sat_flag is set and stays set for the rest of the frame.
- Saturation is sticky: a clamped accumulator continues from the clamped value.
- Counter: cnt increments per accepted sample. Two cases:
  - cnt < LEN-1: acc <= sum, cnt <= cnt+1.
  - cnt == LEN-1 (frame end): out_r/out_i <= sum, out_sat <= sat_flag | this-cycle sat, out_valid <= 1, acc <= 0, sat_flag <= 0, cnt <= 0.
- Latency: the sum is visible the cycle after the LEN-th sample is accepted. Back-to-back frames run with no bubble.
- Output handshake: when out_valid & out_ready, the result is consumed. out_valid <= 0 unless a frame end occurs in the same cycle.
  - Frame end with out_ready=1 in the same cycle: the new result loads, out_valid stays 1, no overrun.
  - Frame end with out_valid=1, out_ready=0: the new result overwrites, overrun <= 1.
- Output stability: while out_valid=1 and no frame end occurs, out_* are held stable.
- clear: acc, cnt and sat_flag <= 0, overrun <= 0. Any sample presented the same cycle is discarded (clear wins). The pending output register and out_valid are not affected.
- Mid-operation reset: reset asserted at any time immediately zeroes all state. A partial frame is lost, and no out_valid is produced for it.
- Two states, implicit in cnt and out_valid. No explicit FSM.
  - ACCUM: cnt in 0..LEN-1.
  - HOLD: out_valid=1, concurrent with ACCUM.

Decomposition:
- Package cplx_pkg: widths N and ACC_W as localparams, plus a signed-saturation helper function shared with other complex blocks.
- Sub-module cplx_sat_add: one-lane saturating adder, combinational, with a sat output. Instantiated twice, for the real and imaginary lanes.
- Counter, flags and output register live in cplx_frame_accum.

Test Plan:
- Nominal frame: LEN=4, in_valid continuous, in_r=100, in_i=-50 for 4 cycles -> out_valid=1 next cycle, out_r=400, out_i=-200, out_sat=0.
- Gapped input: LEN=4, samples 1,2,3,4 (real) with idle cycles between -> out_r=10 only after the 4th accepted sample. cnt sequence is 1,2,3,0.
- Saturation: ACC_W=17, LEN=4, in_r=32767 x4 -> out_r=65535, out_sat=1. Next frame of zeros -> out_r=0, out_sat=0.
- Overrun: LEN=2, out_ready=0, two complete frames (3+4, then 5+6) -> out_r=11, overrun=1. With out_ready=1 on the second frame-end cycle instead -> overrun stays 0, 7 consumed, then 11 presented.
- Clear: LEN=4, accept 3 samples of 9, then clear with in_valid=1 in_r=9 -> sample dropped, cnt=0. Next 4 samples of 1 -> out_r=4.
- Async reset: assert reset mid-frame (cnt=2) with out_valid=1 -> out_valid, cnt, overrun = 0 within the same cycle, without waiting for a clk edge.
